// File: rtl/p_mac_seq.sv
// Perceptron multiply-accumulate sequencer: streams operand pairs through p_mult
// and accumulates the products onto a bias with saturation.

package p_mac_seq_pkg;
    typedef enum logic [1:0] {DT_BOOL = 2'd0, DT_INT = 2'd1, DT_FXP = 2'd2, DT_FP = 2'd3} dtype_e;

    typedef struct packed {
        dtype_e     dtype;
        logic       sgn;
        logic [7:0] prec;
        logic [7:0] frac;
    } dconf_t;

    localparam dconf_t DEF_DCONF = '{dtype: DT_INT, sgn: 1'b1, prec: 8'd16, frac: 8'd0};
endpackage

// Fixed-point multiplier: aligns the product to O_CONF (round half up), then saturates.
module p_mult
    import p_mac_seq_pkg::*;
#(
    parameter dconf_t I1_CONF = DEF_DCONF,
    parameter dconf_t I2_CONF = DEF_DCONF,
    parameter dconf_t O_CONF  = DEF_DCONF
) (
    input  logic [I1_CONF.prec-1:0] a,
    input  logic [I2_CONF.prec-1:0] b,
    output logic [O_CONF.prec-1:0]  p,
    output logic                    ovf,
    output logic                    udf,
    output logic                    rounded
);
    localparam int unsigned W1   = 32'(I1_CONF.prec);
    localparam int unsigned W2   = 32'(I2_CONF.prec);
    localparam int unsigned WO   = 32'(O_CONF.prec);
    localparam int unsigned F12  = 32'(I1_CONF.frac) + 32'(I2_CONF.frac);
    localparam int unsigned FO   = 32'(O_CONF.frac);
    localparam int unsigned SHR  = (F12 > FO) ? F12 - FO : 0;
    localparam int unsigned SHL  = (FO > F12) ? FO - F12 : 0;
    localparam int unsigned EW_P = W1 + W2 + SHL + 2;
    localparam int unsigned EW   = (EW_P > WO + 2) ? EW_P : WO + 2;
    localparam logic        SGN  = O_CONF.sgn;

    localparam logic signed [EW-1:0] HI = SGN ? (EW'(1) <<< (WO - 1)) - EW'(1)
                                              : (EW'(1) <<< WO) - EW'(1);
    localparam logic signed [EW-1:0] LO = SGN ? -(EW'(1) <<< (WO - 1)) : EW'(0);

    logic signed [EW-1:0] ax, bx, full, shifted;

    // Unsigned formats zero-extend, so the signed datapath holds them as non-negative values.
    assign ax   = {{(EW - W1){SGN & a[W1-1]}}, a};
    assign bx   = {{(EW - W2){SGN & b[W2-1]}}, b};
    assign full = ax * bx;

    if (SHR > 0) begin : g_round
        localparam logic signed [EW-1:0] HALF = EW'(1) <<< (SHR - 1);
        assign rounded = |full[SHR-1:0];
        assign shifted = (full + HALF) >>> SHR;
    end else begin : g_align
        assign rounded = 1'b0;
        assign shifted = full <<< SHL;
    end

    always_comb begin
        ovf = 1'b0;
        udf = 1'b0;
        p   = shifted[WO-1:0];
        if (shifted > HI) begin
            ovf = 1'b1;
            p   = HI[WO-1:0];
        end else if (shifted < LO) begin
            udf = 1'b1;
            p   = LO[WO-1:0];
        end
    end
endmodule

module p_mac_seq
    import p_mac_seq_pkg::*;
#(
    parameter dconf_t      I1_CONF = DEF_DCONF,
    parameter dconf_t      I2_CONF = DEF_DCONF,
    parameter dconf_t      O_CONF  = DEF_DCONF,
    parameter int unsigned LEN_W   = 8
) (
    input  logic                    clk,
    input  logic                    reset_,
    input  logic                    start,
    input  logic [LEN_W-1:0]        len,
    input  logic [O_CONF.prec-1:0]  bias,
    output logic                    busy,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [I1_CONF.prec-1:0] in1,
    input  logic [I2_CONF.prec-1:0] in2,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [O_CONF.prec-1:0]  out,
    output logic                    ovf,
    output logic                    udf,
    output logic                    rounded
);
    localparam int unsigned AW  = 32'(O_CONF.prec);
    localparam logic        SGN = O_CONF.sgn;

    if (I1_CONF.dtype != DT_INT && I1_CONF.dtype != DT_FXP) begin : g_bad_dtype
        $error("p_mac_seq: operand format must be INT or FXP");
    end
    if (I2_CONF.dtype != I1_CONF.dtype || O_CONF.dtype != I1_CONF.dtype ||
        I2_CONF.sgn != I1_CONF.sgn || O_CONF.sgn != I1_CONF.sgn) begin : g_bad_mix
        $error("p_mac_seq: operand and result formats must share dtype and signedness");
    end

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

    state_e           state;
    logic [LEN_W-1:0] len_r, cnt;
    logic [AW-1:0]    acc, prod_r, m_p, acc_next;
    logic             prod_v, m_ovf, m_udf, m_rnd;
    logic [AW:0]      sum;
    logic             sat_hi, sat_lo, accept, last;

    p_mult #(
        .I1_CONF(I1_CONF),
        .I2_CONF(I2_CONF),
        .O_CONF (O_CONF)
    ) u_mult (
        .a      (in1),
        .b      (in2),
        .p      (m_p),
        .ovf    (m_ovf),
        .udf    (m_udf),
        .rounded(m_rnd)
    );

    assign out    = acc;
    assign accept = (state == RUN) && in_valid && in_ready;
    assign last   = (cnt + 1'b1) == len_r;

    // One-bit-wider add; signed overflow shows as disagreement of the top two sum bits.
    always_comb begin
        sum      = {SGN & acc[AW-1], acc} + {SGN & prod_r[AW-1], prod_r};
        sat_hi   = 1'b0;
        sat_lo   = 1'b0;
        acc_next = sum[AW-1:0];
        if (SGN) begin
            sat_hi = !sum[AW] && sum[AW-1];
            sat_lo = sum[AW] && !sum[AW-1];
        end else begin
            sat_hi = sum[AW];
        end
        if (sat_hi) begin
            acc_next = SGN ? {1'b0, {(AW - 1){1'b1}}} : {AW{1'b1}};
        end else if (sat_lo) begin
            acc_next = {1'b1, {(AW - 1){1'b0}}};
        end
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state     <= IDLE;
            len_r     <= '0;
            cnt       <= '0;
            acc       <= '0;
            prod_r    <= '0;
            prod_v    <= 1'b0;
            ovf       <= 1'b0;
            udf       <= 1'b0;
            rounded   <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            prod_v  <= accept;
            if (accept) begin
                prod_r <= m_p;
            end
            if (prod_v) begin
                acc <= acc_next;
            end
            ovf     <= ovf | (accept & m_ovf) | (prod_v & sat_hi);
            udf     <= udf | (accept & m_udf) | (prod_v & sat_lo);
            rounded <= rounded | (accept & m_rnd);

            case (state)
                IDLE: begin
                    if (start) begin
                        len_r   <= len;
                        cnt     <= '0;
                        acc     <= bias;
                        ovf     <= 1'b0;
                        udf     <= 1'b0;
                        rounded <= 1'b0;
                        busy    <= 1'b1;
                        if (len == '0) begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                        end else begin
                            state    <= RUN;
                            in_ready <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (accept) begin
                        cnt <= cnt + 1'b1;
                        if (last) begin
                            state    <= DRAIN;
                            in_ready <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    state     <= DONE;
                    out_valid <= 1'b1;
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
